mem_arb: RTL

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arb_pick.sv | 27 ++
 rtl/mem_arb.sv | 104 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding and owner ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC  = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for mem_arb. ARB_RR_EN selects round-robin ties; otherwise m0 has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic winner
);

`ifdef ARB_RR_EN
  // ptr holds the last granted requester, so a tie goes to the other one
  always_comb begin
    if (req0 && req1) winner = ~ptr;
    else if (req0)    winner = OWN_M0;
    else if (req1)    winner = OWN_M1;
    else              winner = ptr;
  end
`else
  always_comb begin
    if (req0)      winner = OWN_M0;
    else if (req1) winner = OWN_M1;
    else           winner = ptr;
  end
`endif

endmodule

// File: rtl/mem_arb.sv
// Two-requester arbiter in front of a single-port, 1-cycle-latency memory.
// Tie policy is selected by the ARB_RR_EN macro (see mem_arb_pick).
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises req with we/addr/wdata and holds them until
  // its ready pulses for one cycle; the access is committed once sampled in IDLE,
  // and a req still high during the ready cycle is a fresh request.

  state_t              state, state_n;
  logic                ptr;
  logic                winner;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                any_req;

  assign any_req = m0_req | m1_req;

  mem_arb_pick u_pick (
    .req0   (m0_req),
    .req1   (m1_req),
    .ptr    (ptr),
    .winner (winner)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = ACC;
      ACC:     state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= OWN_M1;
      owner     <= OWN_M0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata     <= '0;
      m0_ready  <= 1'b0;
      m1_ready  <= 1'b0;
    end else begin
      state    <= state_n;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= winner;
            ptr       <= winner;
            lat_we    <= (winner == OWN_M1) ? m1_we    : m0_we;
            lat_addr  <= (winner == OWN_M1) ? m1_addr  : m0_addr;
            lat_wdata <= (winner == OWN_M1) ? m1_wdata : m0_wdata;
          end
        end
        RESP: begin
          rdata    <= mem_rdata;
          m0_ready <= (owner == OWN_M0);
          m1_ready <= (owner == OWN_M1);
        end
        default: ;
      endcase
    end
  end

  // Address/data stay on the latched values so the bus is quiet between accesses
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_we    = (state == ACC) && lat_we;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
